// File: rtl/shift_seq_engine.sv
// shift_seq_engine: multi-cycle shift sequencer, one single-bit shift per clock over valid/ready.
// Optional macro SHIFT_SEQ_ENGINE_CARRY_EN keeps the carry register; without it out_co is tied to 0.
module shift_seq_engine #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_co,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q;
    logic [AMT_W-1:0] cnt_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

    // One-position shift of the working register; sel[0] picks direction, sel[1] sign fill on right shifts
    always_comb begin
        data_d = sel_q[0] ? {sel_q[1] & data_q[WIDTH-1], data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], 1'b0};
    end

    // Sequencer: accept in IDLE, count shifts down in SHIFT, hold result in DONE until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_q  <= in_data;
                    sel_q   <= in_sel;
                    cnt_q   <= in_amt;
                    state_q <= (in_amt == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_SEQ_ENGINE_CARRY_EN
    logic co_q, co_d;

    // Bit leaving the register on the current step: MSB for left shifts, LSB for right shifts
    always_comb begin
        co_d = sel_q[0] ? data_q[0] : data_q[WIDTH-1];
    end

    // Carry is cleared on accept and tracks the last shifted-out bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) co_q <= 1'b0;
        else if (state_q == IDLE && in_valid) co_q <= 1'b0;
        else if (state_q == SHIFT) co_q <= co_d;
    end

    assign out_co = co_q;
`else
    assign out_co = 1'b0;
`endif
endmodule

// File: tb/tb_shift_seq_engine.sv
// tb_shift_seq_engine: randomized and directed checks of shift_seq_engine against an arithmetic model.
module tb_shift_seq_engine;
`ifdef SHIFT_SEQ_ENGINE_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic [2:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_co;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    shift_seq_engine #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_co(out_co), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Shift by the whole amount at once using integer arithmetic on the 4-bit value
    function automatic void model(input int d, input int s, input int a, output int r, output int c);
        int sd;
        if (s == 0 || s == 2) begin
            r = (d << a) & 15;
            c = ((d << a) >> 4) & 1;
        end else if (s == 1) begin
            r = d >> a;
            c = (a == 0) ? 0 : ((d >> (a - 1)) & 1);
        end else begin
            sd = (d >= 8) ? d - 16 : d;
            r = (sd >>> a) & 15;
            c = (a == 0) ? 0 : ((sd >>> (a - 1)) & 1);
        end
        c = CEN ? c : 0;
    endfunction

    task automatic issue(input logic [3:0] d, input logic [1:0] s, input logic [2:0] a,
                         output int lat, output logic [3:0] od, output logic oc);
        int n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; in_data = d; in_sel = s; in_amt = a;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 4'($urandom); in_sel = 2'($urandom); in_amt = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        od = out_data; oc = out_co;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (out_data !== 4'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
        n_total++; if (out_co !== 1'b0) $display("FAIL reset_out_co got %b exp 0", out_co); else n_pass++;
        in_valid = 1'b1; in_data = 4'hF; in_amt = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_ignores_valid busy got %b exp 0", busy); else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_directed();
        logic [3:0] td [6] = '{4'b1011, 4'b1000, 4'b1000, 4'b1011, 4'b1111, 4'b1001};
        logic [1:0] ts [6] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [2:0] ta [6] = '{3'd1, 3'd2, 3'd2, 3'd0, 3'd7, 3'd7};
        logic [3:0] er [6] = '{4'b0110, 4'b1110, 4'b0010, 4'b1011, 4'b0000, 4'b1111};
        logic       ec [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        logic [3:0] od;
        logic oc;
        for (int i = 0; i < 6; i++) begin
            issue(td[i], ts[i], ta[i], lat, od, oc);
            n_total++; if (lat !== int'(ta[i]) + 1) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, int'(ta[i]) + 1); else n_pass++;
            n_total++; if (od !== er[i]) $display("FAIL dir%0d_data got %b exp %b", i, od, er[i]); else n_pass++;
            n_total++; if (oc !== (ec[i] & CEN)) $display("FAIL dir%0d_co got %b exp %b", i, oc, ec[i] & CEN); else n_pass++;
            drain();
            n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL dir%0d_release got rdy=%b vld=%b exp rdy=1 vld=0", i, in_ready, out_valid); else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, r, c;
        logic [3:0] d, od;
        logic [1:0] s;
        logic [2:0] a;
        logic oc;
        for (int i = 0; i < 40; i++) begin
            d = 4'($urandom); s = 2'($urandom); a = 3'($urandom);
            model(int'(d), int'(s), int'(a), r, c);
            issue(d, s, a, lat, od, oc);
            n_total++; if (lat !== int'(a) + 1) $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, int'(a) + 1); else n_pass++;
            n_total++; if (od !== 4'(r)) $display("FAIL rnd%0d_data d=%b s=%b a=%0d got %b exp %b", i, d, s, a, od, 4'(r)); else n_pass++;
            n_total++; if (oc !== 1'(c)) $display("FAIL rnd%0d_co d=%b s=%b a=%0d got %b exp %b", i, d, s, a, oc, 1'(c)); else n_pass++;
            n_total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL rnd%0d_done_flags got busy=%b rdy=%b exp busy=1 rdy=0", i, busy, in_ready); else n_pass++;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] od;
        logic oc;
        issue(4'b0110, 2'b01, 3'd1, lat, od, oc);
        n_total++; if (od !== 4'b0011) $display("FAIL bp_data got %b exp 0011", od); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_data = 4'hA; in_sel = 2'b00; in_amt = 3'd0;
            @(posedge clk); #1;
            n_total++; if (out_data !== 4'b0011 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got data=%b vld=%b rdy=%b exp data=0011 vld=1 rdy=0", i, out_data, out_valid, in_ready);
            else n_pass++;
        end
        in_valid = 1'b0;
        drain();
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); else n_pass++;
        issue(4'b0101, 2'b00, 3'd2, lat, od, oc);
        n_total++; if (od !== 4'b0100 || lat !== 3) $display("FAIL bp_next got data=%b lat=%0d exp data=0100 lat=3", od, lat); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        logic [3:0] od;
        logic oc;
        in_valid = 1'b1; in_data = 4'b1101; in_sel = 2'b00; in_amt = 3'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_data !== 4'h0 || out_co !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset got data=%b co=%b vld=%b rdy=%b exp 0000 0 0 1", out_data, out_co, out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            n_total++; if (out_valid !== 1'b0) $display("FAIL mid_no_output got %b exp 0", out_valid); else n_pass++;
        end
        issue(4'b0001, 2'b00, 3'd3, lat, od, oc);
        n_total++; if (od !== 4'b1000 || oc !== 1'b0 || lat !== 4) $display("FAIL mid_after got data=%b co=%b lat=%0d exp 1000 0 4", od, oc, lat); else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int cnt, r, c;
        logic got, oc;
        logic [3:0] d, od;
        logic [1:0] s;
        logic [2:0] a;
        out_ready = 1'b1;
        d = 4'($urandom); s = 2'($urandom); a = 3'($urandom);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = d; in_sel = s; in_amt = a;
            model(int'(d), int'(s), int'(a), r, c);
            cnt = 0;
            while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
            @(posedge clk); #1;
            d = 4'($urandom); s = 2'($urandom);
            in_data = d; in_sel = s; in_amt = 3'($urandom);
            cnt = 1; got = 1'b0; od = '0; oc = 1'b0;
            while (!in_ready && cnt < 20) begin
                if (out_valid) begin got = 1'b1; od = out_data; oc = out_co; end
                @(posedge clk); #1; cnt++;
            end
            n_total++; if (cnt !== int'(a) + 2) $display("FAIL b2b%0d_spacing got %0d exp %0d", i, cnt, int'(a) + 2); else n_pass++;
            n_total++; if (!got || od !== 4'(r) || oc !== 1'(c)) $display("FAIL b2b%0d_result got vld=%b data=%b co=%b exp vld=1 data=%b co=%b", i, got, od, oc, 4'(r), 1'(c)); else n_pass++;
            a = in_amt;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_seq_engine.md
# shift_seq_engine

Multi-cycle shift sequencer that sits directly upstream of the 4-bit combinational shift-operator stage. It accepts a shift command (operand, 2-bit op select, shift amount) over a valid/ready handshake. It performs the requested number of single-bit shifts, one per clock, using the same op encoding as the shift-operator stage. The result is presented on a valid/ready output, so multi-position shifts can be built from the single-position operator.

## Interface

Parameters:
- WIDTH, 4, operand/result width in bits
- AMT_W, 3, width of shift-amount field (max amount 2^AMT_W − 1)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  command present
- in_ready  output  1  engine can accept command
- in_data  input  WIDTH  operand
- in_sel  input  2  op: 00 logical left, 01 logical right, 10 arithmetic left, 11 arithmetic right
- in_amt  input  AMT_W  number of bit positions to shift
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  shifted result
- out_co  output  1  carry: last bit shifted out
- busy  output  1  engine not IDLE

## Operation

- States: IDLE, SHIFT, DONE. `in_ready` = (state==IDLE). `out_valid` = (state==DONE). `busy` = (state!=IDLE). All three are combinational decodes of the state register.
- **IDLE, in_valid=1 (accept):**
  - Register data into the working register, sel into the op register, and amt into the down-counter.
  - Clear carry.
  - If amt==0, go to DONE; otherwise go to SHIFT.
- **SHIFT, per clock:** apply one single-bit shift to the working register, update carry, decrement the counter. When the counter reaches 0 on that edge, go to DONE.
- **DONE:** hold out_data/out_co stable. When out_valid && out_ready, go to IDLE. Commands are never accepted in DONE or SHIFT.
- **Single-bit shift rules:**
  - 00/10: shift left, bit 0 filled with 0, carry = old MSB. Arithmetic left is identical to logical left.
  - 01: shift right, MSB filled with 0, carry = old bit 0.
  - 11: shift right, MSB replicated (true sign fill regardless of signedness of surrounding nets), carry = old bit 0.
- **Amounts ≥ WIDTH** are legal and run the full count. Left/logical right end at all zeros; arithmetic right ends at all sign bits. Carry follows the per-step rule.
- in_sel/in_amt/in_data are sampled only at the accept edge. Later changes are ignored.
- **Reset (asynchronous, any state, including mid-SHIFT):**
  - State returns to IDLE.
  - out_data=0, out_co=0, working/op/counter registers cleared.
  - The in-flight command is discarded with no output.
  - in_ready reads 1 during reset, but in_valid is ignored while rst_n=0.

## Timing

- Accept edge E0 (in_valid && in_ready sampled high). out_valid rises after edge E0+amt, i.e. latency amt+1 cycles; amt=0 gives 1 cycle.
- The output holds indefinitely under back-pressure (out_ready=0).
- in_ready rises the cycle after the output handshake edge. Minimum command-to-command spacing is amt+2 cycles.
- No combinational path from in_* or out_ready to any output.

## Configuration

- Macro `SHIFT_SEQ_ENGINE_CARRY_EN`.
- **Defined:** out_co carries the last shifted-out bit as specified. It is 0 for amt=0.
- **Not defined:** the carry register is removed and out_co is tied to constant 0. All other behaviour and latency are unchanged.

## Test plan

- WIDTH=4, sel=00, data=1011, amt=1 → out_data=0110, out_co=1, out_valid 2 cycles after accept.
- sel=11, data=1000, amt=2 → out_data=1110, out_co=0, latency 3; repeat sel=01 → 0010, out_co=0.
- sel=01, data=1011, amt=0 → out_data=1011, out_co=0, out_valid 1 cycle after accept.
- Overshift, amt=7:
  - sel=10, data=1111 → 0000, out_co=0.
  - sel=11, data=1001 → 1111, out_co=1.
- Back-pressure: out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0, in_valid pulses with other data not accepted. Release → IDLE next cycle, then the next command is accepted.
- Reset mid-SHIFT (amt=5, after 2 shifts) → outputs 0 immediately, no out_valid. After release, a new command with sel=00, data=0001, amt=3 yields 1000.
